hci_core_join: RTL and testbench

//  Inverse of the HCI core lane splitter: joins NB_IN_CHAN narrow HCI initiator lanes into one wide HCI request.

---
 rtl/hci_core_join.sv | 231 +++++++++++++++++++++++
 tb/tb_hci_core_join.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/hci_core_join.sv
// hci_core_join: joins NB_IN_CHAN narrow HCI initiator lanes into a single
// wide HCI request and fans the wide read response back out per lane.
// Each lane is granted and latched on its own. The wide request issues once
// every lane is latched. Only one wide transaction is outstanding at a time.
// Optional feature macro: HCI_CORE_JOIN_CHECK_EN. When it is defined, a
// lane-consistency check drives a sticky err_o. When it is not defined,
// err_o is tied to 0.
module hci_core_join #(
    parameter int unsigned DW_OUT     = 64,
    parameter int unsigned NB_IN_CHAN = 2,
    parameter int unsigned AW         = 32,
    parameter int unsigned UW         = 2,
    localparam int unsigned DW_IN     = DW_OUT / NB_IN_CHAN,
    localparam int unsigned BW_IN     = DW_IN / 8,
    localparam int unsigned BW_OUT    = DW_OUT / 8
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       clear_i,
    input  logic [NB_IN_CHAN-1:0]      in_req_i,
    output logic [NB_IN_CHAN-1:0]      in_gnt_o,
    input  logic [NB_IN_CHAN*AW-1:0]   in_add_i,
    input  logic [NB_IN_CHAN-1:0]      in_wen_i,
    input  logic [NB_IN_CHAN*BW_IN-1:0] in_be_i,
    input  logic [NB_IN_CHAN*DW_IN-1:0] in_data_i,
    input  logic [NB_IN_CHAN*UW-1:0]   in_user_i,
    input  logic [NB_IN_CHAN-1:0]      in_lrdy_i,
    output logic [NB_IN_CHAN-1:0]      in_r_valid_o,
    output logic [NB_IN_CHAN*DW_IN-1:0] in_r_data_o,
    output logic [NB_IN_CHAN*UW-1:0]   in_r_user_o,
    output logic                       out_req_o,
    input  logic                       out_gnt_i,
    output logic [AW-1:0]              out_add_o,
    output logic                       out_wen_o,
    output logic [BW_OUT-1:0]          out_be_o,
    output logic [DW_OUT-1:0]          out_data_o,
    output logic [UW-1:0]              out_user_o,
    output logic                       out_lrdy_o,
    input  logic                       out_r_valid_i,
    input  logic [DW_OUT-1:0]          out_r_data_i,
    input  logic [UW-1:0]              out_r_user_i,
    output logic                       err_o
);

    typedef enum logic [1:0] {
        COLLECT = 2'd0,
        ISSUE   = 2'd1,
        RESP    = 2'd2
    } state_e;

    state_e                        state_q, state_d;
    logic [NB_IN_CHAN-1:0]         collected_q, collected_d;
    logic [NB_IN_CHAN-1:0]         delivered_q, delivered_d;
    logic                          rsp_got_q, rsp_got_d;
    logic [NB_IN_CHAN*AW-1:0]      add_q, add_d;
    logic [NB_IN_CHAN-1:0]         wen_q, wen_d;
    logic [NB_IN_CHAN*BW_IN-1:0]   be_q, be_d;
    logic [NB_IN_CHAN*DW_IN-1:0]   data_q, data_d;
    logic [NB_IN_CHAN*UW-1:0]      user_q, user_d;
    logic [DW_OUT-1:0]             rdata_q, rdata_d;
    logic [UW-1:0]                 ruser_q, ruser_d;
    logic                          err_q, err_d;
    logic [NB_IN_CHAN-1:0]         gnt_s;
    logic [NB_IN_CHAN-1:0]         deliver_s;
    logic                          mismatch_s;

    // Next-state logic: lane collection, wide issue, and response drain.
    always_comb begin
        state_d     = state_q;
        collected_d = collected_q;
        delivered_d = delivered_q;
        rsp_got_d   = rsp_got_q;
        add_d       = add_q;
        wen_d       = wen_q;
        be_d        = be_q;
        data_d      = data_q;
        user_d      = user_q;
        rdata_d     = rdata_q;
        ruser_d     = ruser_q;
        gnt_s       = '0;
        deliver_s   = '0;
        case (state_q)
            COLLECT: begin
                gnt_s = in_req_i & ~collected_q;
                for (int i = 0; i < int'(NB_IN_CHAN); i++) begin
                    if (gnt_s[i]) begin
                        add_d[i*AW +: AW]       = in_add_i[i*AW +: AW];
                        wen_d[i]                = in_wen_i[i];
                        be_d[i*BW_IN +: BW_IN]  = in_be_i[i*BW_IN +: BW_IN];
                        data_d[i*DW_IN +: DW_IN] = in_data_i[i*DW_IN +: DW_IN];
                        user_d[i*UW +: UW]      = in_user_i[i*UW +: UW];
                    end else begin
                        add_d[i*AW +: AW]       = add_q[i*AW +: AW];
                    end
                end
                collected_d = collected_q | gnt_s;
                if (&collected_d) begin
                    state_d = ISSUE;
                end else begin
                    state_d = COLLECT;
                end
            end
            ISSUE: begin
                if (out_gnt_i) begin
                    if (wen_q[0]) begin
                        state_d = RESP;
                    end else begin
                        state_d     = COLLECT;
                        collected_d = '0;
                    end
                end else begin
                    state_d = ISSUE;
                end
            end
            RESP: begin
                if (!rsp_got_q) begin
                    // Capture the wide response once; lanes see it next cycle.
                    if (out_r_valid_i) begin
                        rdata_d   = out_r_data_i;
                        ruser_d   = out_r_user_i;
                        rsp_got_d = 1'b1;
                    end else begin
                        rsp_got_d = 1'b0;
                    end
                end else begin
                    deliver_s   = ~delivered_q & in_lrdy_i;
                    delivered_d = delivered_q | deliver_s;
                    if (&delivered_d) begin
                        state_d     = COLLECT;
                        collected_d = '0;
                        delivered_d = '0;
                        rsp_got_d   = 1'b0;
                    end else begin
                        state_d = RESP;
                    end
                end
            end
            default: begin
                state_d     = COLLECT;
                collected_d = '0;
                delivered_d = '0;
                rsp_got_d   = 1'b0;
            end
        endcase
    end

`ifdef HCI_CORE_JOIN_CHECK_EN
    // Lane-consistency check, evaluated on the fields that will be presented in ISSUE.
    always_comb begin
        mismatch_s = 1'b0;
        for (int i = 1; i < int'(NB_IN_CHAN); i++) begin
            if ((add_d[i*AW +: AW] != (add_d[AW-1:0] + AW'(i) * AW'(BW_IN))) ||
                (wen_d[i] != wen_d[0]) ||
                (user_d[i*UW +: UW] != user_d[UW-1:0])) begin
                mismatch_s = 1'b1;
            end else begin
                mismatch_s = mismatch_s;
            end
        end
        if ((state_q == COLLECT) && (&collected_d)) begin
            err_d = err_q | mismatch_s;
        end else begin
            err_d = err_q;
        end
    end
`else
    // Consistency checking is not built; the error flag stays low.
    always_comb begin
        mismatch_s = 1'b0;
        err_d      = 1'b0;
    end
`endif

    // State and datapath registers; clear_i behaves like reset and wins over any grant.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= COLLECT;
            collected_q <= '0;
            delivered_q <= '0;
            rsp_got_q   <= 1'b0;
            add_q       <= '0;
            wen_q       <= '0;
            be_q        <= '0;
            data_q      <= '0;
            user_q      <= '0;
            rdata_q     <= '0;
            ruser_q     <= '0;
            err_q       <= 1'b0;
        end else if (clear_i) begin
            state_q     <= COLLECT;
            collected_q <= '0;
            delivered_q <= '0;
            rsp_got_q   <= 1'b0;
            add_q       <= '0;
            wen_q       <= '0;
            be_q        <= '0;
            data_q      <= '0;
            user_q      <= '0;
            rdata_q     <= '0;
            ruser_q     <= '0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            collected_q <= collected_d;
            delivered_q <= delivered_d;
            rsp_got_q   <= rsp_got_d;
            add_q       <= add_d;
            wen_q       <= wen_d;
            be_q        <= be_d;
            data_q      <= data_d;
            user_q      <= user_d;
            rdata_q     <= rdata_d;
            ruser_q     <= ruser_d;
            err_q       <= err_d;
        end
    end

    assign in_gnt_o     = gnt_s;
    assign out_req_o    = (state_q == ISSUE);
    assign out_add_o    = add_q[AW-1:0];
    assign out_wen_o    = wen_q[0];
    assign out_be_o     = be_q;
    assign out_data_o   = data_q;
    assign out_user_o   = user_q[UW-1:0];
    assign out_lrdy_o   = (state_q != RESP) | ~rsp_got_q;
    assign in_r_valid_o = ((state_q == RESP) && rsp_got_q) ? ~delivered_q : '0;
    assign in_r_data_o  = rdata_q;
    assign in_r_user_o  = {NB_IN_CHAN{ruser_q}};
    assign err_o        = err_q;

endmodule

// File: tb/tb_hci_core_join.sv
// Directed testbench for hci_core_join (NB_IN_CHAN=2, DW_OUT=64, AW=32, UW=2).
module tb_hci_core_join;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        clear_i;
    logic [1:0]  in_req_i;
    logic [1:0]  in_gnt_o;
    logic [63:0] in_add_i;
    logic [1:0]  in_wen_i;
    logic [7:0]  in_be_i;
    logic [63:0] in_data_i;
    logic [3:0]  in_user_i;
    logic [1:0]  in_lrdy_i;
    logic [1:0]  in_r_valid_o;
    logic [63:0] in_r_data_o;
    logic [3:0]  in_r_user_o;
    logic        out_req_o;
    logic        out_gnt_i;
    logic [31:0] out_add_o;
    logic        out_wen_o;
    logic [7:0]  out_be_o;
    logic [63:0] out_data_o;
    logic [1:0]  out_user_o;
    logic        out_lrdy_o;
    logic        out_r_valid_i;
    logic [63:0] out_r_data_i;
    logic [1:0]  out_r_user_i;
    logic        err_o;

    int n_pass  = 0;
    int n_total = 0;
    logic err_exp;

    hci_core_join #(.DW_OUT(64), .NB_IN_CHAN(2), .AW(32), .UW(2)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .clear_i(clear_i),
        .in_req_i(in_req_i), .in_gnt_o(in_gnt_o), .in_add_i(in_add_i),
        .in_wen_i(in_wen_i), .in_be_i(in_be_i), .in_data_i(in_data_i),
        .in_user_i(in_user_i), .in_lrdy_i(in_lrdy_i), .in_r_valid_o(in_r_valid_o),
        .in_r_data_o(in_r_data_o), .in_r_user_o(in_r_user_o),
        .out_req_o(out_req_o), .out_gnt_i(out_gnt_i), .out_add_o(out_add_o),
        .out_wen_o(out_wen_o), .out_be_o(out_be_o), .out_data_o(out_data_o),
        .out_user_o(out_user_o), .out_lrdy_o(out_lrdy_o),
        .out_r_valid_i(out_r_valid_i), .out_r_data_i(out_r_data_i),
        .out_r_user_i(out_r_user_i), .err_o(err_o)
    );

    // Free-running clock, 10 time-unit period.
    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    initial begin
`ifdef HCI_CORE_JOIN_CHECK_EN
        err_exp = 1'b1;
`else
        err_exp = 1'b0;
`endif
        rst_i = 1'b1; clear_i = 1'b0; in_req_i = 2'b00; in_add_i = 64'h0;
        in_wen_i = 2'b00; in_be_i = 8'h00; in_data_i = 64'h0; in_user_i = 4'h0;
        in_lrdy_i = 2'b00; out_gnt_i = 1'b0; out_r_valid_i = 1'b0;
        out_r_data_i = 64'h0; out_r_user_i = 2'b00;
        #12;
        chk("rst_out_req", {63'd0, out_req_o}, 64'd0);
        chk("rst_out_lrdy", {63'd0, out_lrdy_o}, 64'd1);
        chk("rst_r_valid", {62'd0, in_r_valid_o}, 64'd0);
        chk("rst_err", {63'd0, err_o}, 64'd0);
        chk("rst_out_add", {32'd0, out_add_o}, 64'd0);
        rst_i = 1'b0;
        tick();

        // T1: both lanes read 0x100/0x104 in the same cycle.
        in_req_i = 2'b11; in_add_i = {32'h0000_0104, 32'h0000_0100};
        in_wen_i = 2'b11; in_be_i = 8'hFF; in_user_i = 4'b0101;
        #1;
        chk("t1_gnt", {62'd0, in_gnt_o}, 64'd3);
        tick();
        chk("t1_req", {63'd0, out_req_o}, 64'd1);
        chk("t1_add", {32'd0, out_add_o}, 64'h100);
        chk("t1_wen", {63'd0, out_wen_o}, 64'd1);
        chk("t1_user", {62'd0, out_user_o}, 64'd1);
        chk("t1_gnt_held_off", {62'd0, in_gnt_o}, 64'd0);
        in_req_i = 2'b00; out_gnt_i = 1'b1;
        tick();
        out_gnt_i = 1'b0;

        // T3: wide response; lane 1 not load-ready for two cycles.
        chk("t3_lrdy_before", {63'd0, out_lrdy_o}, 64'd1);
        chk("t3_no_rvalid_yet", {62'd0, in_r_valid_o}, 64'd0);
        out_r_valid_i = 1'b1; out_r_data_i = 64'hDEADBEEF_CAFEF00D; out_r_user_i = 2'b10;
        tick();
        out_r_valid_i = 1'b0; out_r_data_i = 64'h0;
        in_lrdy_i = 2'b01; in_req_i = 2'b11;
        #1;
        chk("t3_lrdy_after", {63'd0, out_lrdy_o}, 64'd0);
        chk("t3_rvalid_both", {62'd0, in_r_valid_o}, 64'd3);
        chk("t3_rdata0", {32'd0, in_r_data_o[31:0]}, 64'hCAFEF00D);
        chk("t3_rdata1", {32'd0, in_r_data_o[63:32]}, 64'hDEADBEEF);
        chk("t3_ruser", {60'd0, in_r_user_o}, 64'hA);
        chk("t3_no_gnt", {62'd0, in_gnt_o}, 64'd0);
        tick();
        in_lrdy_i = 2'b00;
        #1;
        chk("t3_rvalid_lane1_only", {62'd0, in_r_valid_o}, 64'd2);
        chk("t3_no_gnt2", {62'd0, in_gnt_o}, 64'd0);
        tick();
        in_lrdy_i = 2'b10;
        #1;
        chk("t3_rvalid_lane1_wait", {62'd0, in_r_valid_o}, 64'd2);
        chk("t3_rdata1_late", {32'd0, in_r_data_o[63:32]}, 64'hDEADBEEF);
        chk("t3_no_gnt3", {62'd0, in_gnt_o}, 64'd0);
        tick();
        in_lrdy_i = 2'b00;
        #1;
        chk("t3_drained", {62'd0, in_r_valid_o}, 64'd0);
        chk("t3_new_gnt", {62'd0, in_gnt_o}, 64'd3);
        in_req_i = 2'b00;

        // T2: staggered write lanes, lane 0 at cycle 0, lane 1 at cycle 3.
        in_req_i = 2'b01; in_add_i = {32'h0, 32'h0000_0200}; in_wen_i = 2'b00;
        in_be_i = 8'h03; in_data_i = {32'h0, 32'h1111_1111}; in_user_i = 4'b0000;
        #1;
        chk("t2_gnt0", {62'd0, in_gnt_o}, 64'd1);
        tick();
        in_req_i = 2'b00; in_add_i = 64'hFFFF_FFFF_FFFF_FFFF; in_data_i = 64'h5555_5555_5555_5555;
        tick();
        chk("t2_no_req_c2", {63'd0, out_req_o}, 64'd0);
        tick();
        in_req_i = 2'b11; in_add_i = {32'h0000_0204, 32'hEEEE_EEEE};
        in_be_i = 8'hCF; in_data_i = {32'h2222_2222, 32'h9999_9999};
        #1;
        chk("t2_gnt1_only", {62'd0, in_gnt_o}, 64'd2);
        chk("t2_no_req_c3", {63'd0, out_req_o}, 64'd0);
        tick();
        in_req_i = 2'b00;

        // T4: write issue with out_gnt low for three cycles.
        for (int c = 0; c < 3; c++) begin
            chk("t4_req_held", {63'd0, out_req_o}, 64'd1);
            chk("t4_add", {32'd0, out_add_o}, 64'h200);
            chk("t4_be", {56'd0, out_be_o}, 64'hC3);
            chk("t4_data", out_data_o, 64'h22222222_11111111);
            chk("t4_wen", {63'd0, out_wen_o}, 64'd0);
            tick();
        end
        chk("t4_req_4th", {63'd0, out_req_o}, 64'd1);
        chk("t4_data_4th", out_data_o, 64'h22222222_11111111);
        out_gnt_i = 1'b1;
        tick();
        out_gnt_i = 1'b0;
        in_req_i = 2'b11;
        #1;
        chk("t4_done_req", {63'd0, out_req_o}, 64'd0);
        chk("t4_no_rvalid", {62'd0, in_r_valid_o}, 64'd0);
        chk("t4_collect_gnt", {62'd0, in_gnt_o}, 64'd3);

        // T5: inconsistent lane 1 address (0x108 vs 0x100), read.
        in_add_i = {32'h0000_0108, 32'h0000_0100}; in_wen_i = 2'b11; in_be_i = 8'hFF;
        tick();
        in_req_i = 2'b00;
        chk("t5_err_issue", {63'd0, err_o}, {63'd0, err_exp});
        chk("t5_req", {63'd0, out_req_o}, 64'd1);
        chk("t5_add_unchanged", {32'd0, out_add_o}, 64'h100);
        out_gnt_i = 1'b1;
        tick();
        out_gnt_i = 1'b0;
        chk("t5_err_sticky", {63'd0, err_o}, {63'd0, err_exp});

        // T6: clear in RESP before the wide response arrives.
        clear_i = 1'b1;
        tick();
        clear_i = 1'b0;
        chk("t6_err_cleared", {63'd0, err_o}, 64'd0);
        chk("t6_lrdy", {63'd0, out_lrdy_o}, 64'd1);
        out_r_valid_i = 1'b1; out_r_data_i = 64'h0123_4567_89AB_CDEF;
        tick();
        out_r_valid_i = 1'b0;
        in_req_i = 2'b11;
        #1;
        chk("t6_stray_dropped", {62'd0, in_r_valid_o}, 64'd0);
        chk("t6_collect_gnt", {62'd0, in_gnt_o}, 64'd3);
        in_req_i = 2'b01; in_add_i = {32'h0000_0304, 32'h0000_0300};
        tick();
        chk("t6_rvalid_still0", {62'd0, in_r_valid_o}, 64'd0);
        chk("t6_lane0_only_no_req", {63'd0, out_req_o}, 64'd0);

        // Last-lane grant coinciding with clear: clear wins.
        in_req_i = 2'b10; clear_i = 1'b1;
        tick();
        clear_i = 1'b0;
        in_req_i = 2'b11;
        #1;
        chk("clr_last_no_req", {63'd0, out_req_o}, 64'd0);
        chk("clr_last_regrant", {62'd0, in_gnt_o}, 64'd3);
        chk("clr_last_add", {32'd0, out_add_o}, 64'd0);
        in_req_i = 2'b00;
        tick();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    // Absolute time limit so the run always terminates.
    initial begin
        #100000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
